mem_responder: RTL and testbench

Word-addressed data/instruction memory responder for the multicycle CPU: the slave end of the memory request interface driven by the control unit's fetch, load and store states. It accepts one request at a time via a valid/ready handshake, services it after a fixed, parameterised latency from an internal word array, and returns a single-cycle response pulse carrying read data and an error code. It replaces the bare memory plus hard-coded wait states, so the control FSM can wait on `rsp_valid` instead of counting cycles.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder_array.sv | 40 ++++
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder shared types: FSM states, error codes, request classifier.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } err_t;

    // Misalignment wins over range so a bad low address never reaches the array.
    function automatic err_t classify(
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        if (addr[1:0] != 2'b00) return ERR_MISALIGN;
        if ({2'b00, addr[31:2]} >= depth) return ERR_RANGE;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control unit and mem_responder.
// Optional byte strobes appear when MEM_RESPONDER_BYTE_EN_EN is defined.
interface mem_responder_if;

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef MEM_RESPONDER_BYTE_EN_EN
    logic [3:0]  req_be;
`endif
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_RESPONDER_BYTE_EN_EN
        output req_be,
`endif
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_RESPONDER_BYTE_EN_EN
        input  req_be,
`endif
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mem_responder_array.sv
// Word storage with byte-strobed synchronous write and registered read.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read register doubles as the held response data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: FSM, latency counter, error classification.
// Define MEM_RESPONDER_BYTE_EN_EN to enable per-byte store strobes.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input logic            clock,
    input logic            reset,
    mem_responder_if.slave bus
);

    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW   = ($clog2(MAXL) < 1) ? 1 : $clog2(MAXL);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          finish;
    err_t          req_err;
    logic [3:0]    req_be;
    logic          lat_write;
    logic [AW-1:0] lat_word;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    err_t          lat_err;
    err_t          rsp_err;
    logic          ok;
    logic          we;
    logic          re;
    logic          clr;

    assign req_err = classify(bus.req_addr, 32'(DEPTH_WORDS));

`ifdef MEM_RESPONDER_BYTE_EN_EN
    assign req_be = bus.req_be;
`else
    assign req_be = 4'hF;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        finish = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    nxt    = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    finish = 1'b1;
                    nxt    = RESP;
                end
            end
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_word  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_err   <= ERR_OK;
            rsp_err   <= ERR_OK;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_word  <= bus.req_addr[2 +: AW];
                lat_wdata <= bus.req_wdata;
                lat_be    <= req_be;
                lat_err   <= req_err;
                // Errored requests skip the array, so they always take one edge.
                if (req_err != ERR_OK) cnt <= '0;
                else if (bus.req_write) cnt <= CW'(WRITE_LAT - 1);
                else cnt <= CW'(READ_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) rsp_err <= lat_err;
        end
    end

    assign ok  = (lat_err == ERR_OK);
    assign we  = finish & lat_write & ok & reset;
    assign re  = finish & ~lat_write & ok;
    assign clr = finish & ~re;

    mem_responder_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .we   (we),
        .be   (lat_be),
        .re   (re),
        .clr  (clr),
        .addr (lat_word),
        .wdata(lat_wdata),
        .rdata(bus.rsp_rdata)
    );

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder; byte-strobe checks need MEM_RESPONDER_BYTE_EN_EN.
module tb_mem_responder;

    localparam int RL = 2;
    localparam int WL = 1;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          at;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    exp_t q[$];
    exp_t mon_e;
    logic pv = 1'b0;

    mem_responder_if bus();

    mem_responder #(
        .DEPTH_WORDS(256),
        .READ_LAT   (RL),
        .WRITE_LAT  (WL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (bus.rsp_valid === 1'b1) begin
            chk("rsp_single_pulse", {31'b0, pv}, 32'd0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rdata %h err %b want none",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", {30'b0, bus.rsp_err}, {30'b0, mon_e.err});
                chk("rsp_edge", edge_n, mon_e.at);
            end
        end
        pv = (bus.rsp_valid === 1'b1);
    end

    task automatic issue(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  be,
        input  logic [31:0] er,
        input  logic [1:0]  ee,
        input  int          lat,
        output int          k
    );
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
`ifdef MEM_RESPONDER_BYTE_EN_EN
        bus.req_be    = be;
`endif
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got ready %b want 1 addr %h", bus.req_ready, a);
            k = -1;
        end else begin
            k = edge_n + 1;
            q.push_back('{er, ee, k + lat});
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        bus.req_valid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int k1, k2, k3, k4;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef MEM_RESPONDER_BYTE_EN_EN
        bus.req_be    = 4'hF;
`endif
        reset = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        chk("reset_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_err", {30'b0, bus.rsp_err}, 32'd0);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 2'b00, RL, k1);
        chk("busy_in_wait", {31'b0, bus.busy}, 32'd1);
        chk("ready_in_wait", {31'b0, bus.req_ready}, 32'd0);
        drain();
        chk("rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

        issue(1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 2'b01, 1, k1);
        drain();
        issue(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 2'b10, 1, k1);
        drain();
        issue(1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b1, 32'h400, 32'h0BAD0BAD, 4'hF, 32'h0, 2'b10, 1, k1);
        drain();
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h11111111, 2'b00, RL, k1);
        drain();

        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 2'b00, WL, k1);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        q.delete();
        @(negedge clock);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("abort_valid", {31'b0, bus.rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 2'b00, RL, k1);
        drain();

        issue(1'b1, 32'h8, 32'hA1A1A1A1, 4'hF, 32'h0, 2'b00, WL, k1);
        issue(1'b0, 32'h8, 32'h0, 4'hF, 32'hA1A1A1A1, 2'b00, RL, k2);
        issue(1'b1, 32'h8, 32'hB2B2B2B2, 4'hF, 32'h0, 2'b00, WL, k3);
        issue(1'b0, 32'h8, 32'h0, 4'hF, 32'hB2B2B2B2, 2'b00, RL, k4);
        chk("spacing_st_ld", k2 - k1, WL + 2);
        chk("spacing_ld_st", k3 - k2, RL + 2);
        chk("spacing_st_ld2", k4 - k3, WL + 2);
        drain();

`ifdef MEM_RESPONDER_BYTE_EN_EN
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b1, 32'h30, 32'h00000000, 4'b0101, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b1, 32'h30, 32'h00000000, 4'b0000, 32'h0, 2'b00, WL, k1);
        drain();
        issue(1'b0, 32'h30, 32'h0, 4'b0000, 32'hFF00FF00, 2'b00, RL, k1);
        drain();
`endif

        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
